// File: rtl/pong_pkg.sv
// Shared state encoding and paddle command codes for the Pong session controller.
package pong_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_PLAY,
    S_RESULT,
    S_GAP,
    S_END
  } state_t;

  localparam logic [1:0] PADDLE_UP   = 2'b10;
  localparam logic [1:0] PADDLE_DOWN = 2'b01;
  localparam logic [1:0] PADDLE_HOLD = 2'b00;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/paddle_decoder.sv
// Windowed up/down spike counter that turns spike-count differences into a
// registered paddle command, held for the whole following window.
module paddle_decoder
  import pong_pkg::*;
#(
  parameter int WINDOW_CYCLES = 1000,
  parameter int MARGIN        = 2,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       spike_up,
  input  logic       spike_down,
  output logic [1:0] paddle_control
);

  localparam int               WIN_W    = $clog2(WINDOW_CYCLES);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] up_cnt;
  logic [CNT_W-1:0] down_cnt;
  logic [CNT_W-1:0] up_next;
  logic [CNT_W-1:0] down_next;
  logic [1:0]       paddle_r;
  logic [1:0]       decision;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    up_next   = (spike_up && up_cnt != CNT_MAX) ? up_cnt + CNT_W'(1) : up_cnt;
    down_next = (spike_down && down_cnt != CNT_MAX) ? down_cnt + CNT_W'(1) : down_cnt;
    decision  = PADDLE_HOLD;
    if (int'(up_next) >= int'(down_next) + MARGIN) begin
      decision = PADDLE_UP;
    end else if (int'(down_next) >= int'(up_next) + MARGIN) begin
      decision = PADDLE_DOWN;
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_cnt  <= '0;
      up_cnt   <= '0;
      down_cnt <= '0;
      paddle_r <= PADDLE_HOLD;
    end else if (!enable) begin
      win_cnt  <= '0;
      up_cnt   <= '0;
      down_cnt <= '0;
      paddle_r <= PADDLE_HOLD;
    end else if (win_cnt == WIN_LAST) begin
      win_cnt  <= '0;
      up_cnt   <= '0;
      down_cnt <= '0;
      paddle_r <= decision;
    end else begin
      win_cnt  <= win_cnt + WIN_W'(1);
      up_cnt   <= up_next;
      down_cnt <= down_next;
    end
  end

  // Mask the held command the instant PLAY is left rather than one cycle later.
  assign paddle_control = enable ? paddle_r : PADDLE_HOLD;

endmodule

// File: rtl/pong_session_ctrl.sv
// Host-side session controller for the Game handshake: start/play/result/gap rounds,
// then end. Optional feedback pulses are built when PONG_FEEDBACK_EN is defined.
module pong_session_ctrl
  import pong_pkg::*;
#(
  parameter int NUM_ROUNDS    = 8,
  parameter int WINDOW_CYCLES = 1000,
  parameter int MARGIN        = 2,
  parameter int CNT_W         = 8,
  parameter int GAP_CYCLES    = 16,
  parameter int FB_CYCLES     = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       session_start,
  input  logic       session_abort,
  input  logic       spike_up,
  input  logic       spike_down,
  output logic       game_start_valid,
  input  logic       game_start_ready,
  output logic       game_end_valid,
  input  logic       game_end_ready,
  output logic [1:0] paddle_control,
  input  logic       result_en,
  input  logic       game_result,
  output logic       session_busy,
  output logic       session_done,
  output logic [7:0] win_count,
  output logic [7:0] loss_count,
  output logic       stim_win,
  output logic       stim_loss
);

`ifdef PONG_FEEDBACK_EN
  localparam bit FB_EN = 1'b1;
`else
  localparam bit FB_EN = 1'b0;
`endif

  localparam int               GAP_LEN  = max_int(GAP_CYCLES, FB_EN ? FB_CYCLES : 0);
  localparam int               GAP_W    = $clog2(GAP_LEN + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LEN - 1);
  localparam logic [7:0]       ROUNDS   = 8'(NUM_ROUNDS);

  state_t           state;
  logic [GAP_W-1:0] gap_cnt;
  logic [7:0]       round_cnt;
  logic             seen_low;
  logic             abort_pending;
  logic             start_hs;
  logic             end_hs;
  logic             accept;
  logic             play;

  assign start_hs = (state == S_START) && game_start_valid && game_start_ready;
  assign end_hs   = (state == S_END) && game_end_valid && game_end_ready;
  // seen_low guards against the Game still holding the previous round's result level.
  assign accept   = (state == S_PLAY) && seen_low && result_en && !session_abort;
  assign play     = (state == S_PLAY);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      game_start_valid <= 1'b0;
      game_end_valid   <= 1'b0;
      session_busy     <= 1'b0;
      session_done     <= 1'b0;
      win_count        <= '0;
      loss_count       <= '0;
      round_cnt        <= '0;
      gap_cnt          <= '0;
      seen_low         <= 1'b0;
      abort_pending    <= 1'b0;
    end else begin
      session_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (session_start) begin
            state            <= S_START;
            game_start_valid <= 1'b1;
            session_busy     <= 1'b1;
            win_count        <= '0;
            loss_count       <= '0;
            round_cnt        <= '0;
            abort_pending    <= 1'b0;
          end
        end
        S_START: begin
          if (session_abort) abort_pending <= 1'b1;
          // An abort may not withdraw a pending start request; it is honoured after it.
          if (start_hs) begin
            game_start_valid <= 1'b0;
            abort_pending    <= 1'b0;
            if (abort_pending || session_abort) begin
              state          <= S_END;
              game_end_valid <= 1'b1;
            end else begin
              state    <= S_PLAY;
              seen_low <= 1'b0;
            end
          end
        end
        S_PLAY: begin
          if (session_abort) begin
            state          <= S_END;
            game_end_valid <= 1'b1;
          end else if (accept) begin
            state     <= S_RESULT;
            round_cnt <= round_cnt + 8'd1;
            if (game_result) begin
              win_count <= (win_count == 8'hFF) ? win_count : win_count + 8'd1;
            end else begin
              loss_count <= (loss_count == 8'hFF) ? loss_count : loss_count + 8'd1;
            end
          end else if (!result_en) begin
            seen_low <= 1'b1;
          end
        end
        S_RESULT: begin
          if (session_abort) begin
            state          <= S_END;
            game_end_valid <= 1'b1;
          end else begin
            state   <= S_GAP;
            gap_cnt <= '0;
          end
        end
        S_GAP: begin
          if (session_abort) begin
            state          <= S_END;
            game_end_valid <= 1'b1;
          end else if (gap_cnt == GAP_LAST) begin
            if (round_cnt < ROUNDS) begin
              state            <= S_START;
              game_start_valid <= 1'b1;
            end else begin
              state          <= S_END;
              game_end_valid <= 1'b1;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        S_END: begin
          if (end_hs) begin
            state          <= S_IDLE;
            game_end_valid <= 1'b0;
            session_busy   <= 1'b0;
            session_done   <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PONG_FEEDBACK_EN
  localparam int FB_W = $clog2(FB_CYCLES + 1);

  logic [FB_W-1:0] fb_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fb_cnt    <= '0;
      stim_win  <= 1'b0;
      stim_loss <= 1'b0;
    end else if (accept) begin
      fb_cnt    <= FB_W'(FB_CYCLES - 1);
      stim_win  <= game_result;
      stim_loss <= !game_result;
    end else if (fb_cnt != '0) begin
      fb_cnt <= fb_cnt - FB_W'(1);
    end else begin
      stim_win  <= 1'b0;
      stim_loss <= 1'b0;
    end
  end
`else
  assign stim_win  = 1'b0;
  assign stim_loss = 1'b0;
`endif

  paddle_decoder #(
    .WINDOW_CYCLES(WINDOW_CYCLES),
    .MARGIN       (MARGIN),
    .CNT_W        (CNT_W)
  ) u_paddle_decoder (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (play),
    .spike_up      (spike_up),
    .spike_down    (spike_down),
    .paddle_control(paddle_control)
  );

endmodule

// File: tb/tb_pong_session_ctrl.sv
// Self-checking bench for pong_session_ctrl: decode vector table, directed session,
// abort and reset sequences, then randomized sessions against a behavioural model.
module tb_pong_session_ctrl;

  localparam int NUM_ROUNDS = 2;
  localparam int WINDOW     = 300;
  localparam int MARGIN     = 2;
  localparam int CNT_W      = 8;
  localparam int GAP        = 4;
  localparam int SAT        = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       session_start = 1'b0;
  logic       session_abort = 1'b0;
  logic       spike_up = 1'b0;
  logic       spike_down = 1'b0;
  logic       game_start_ready = 1'b0;
  logic       game_end_ready = 1'b0;
  logic       result_en = 1'b0;
  logic       game_result = 1'b0;
  logic       game_start_valid;
  logic       game_end_valid;
  logic [1:0] paddle_control;
  logic       session_busy;
  logic       session_done;
  logic [7:0] win_count;
  logic [7:0] loss_count;
  logic       stim_win;
  logic       stim_loss;

  pong_session_ctrl #(
    .NUM_ROUNDS   (NUM_ROUNDS),
    .WINDOW_CYCLES(WINDOW),
    .MARGIN       (MARGIN),
    .CNT_W        (CNT_W),
    .GAP_CYCLES   (GAP),
    .FB_CYCLES    (4)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .session_start   (session_start),
    .session_abort   (session_abort),
    .spike_up        (spike_up),
    .spike_down      (spike_down),
    .game_start_valid(game_start_valid),
    .game_start_ready(game_start_ready),
    .game_end_valid  (game_end_valid),
    .game_end_ready  (game_end_ready),
    .paddle_control  (paddle_control),
    .result_en       (result_en),
    .game_result     (game_result),
    .session_busy    (session_busy),
    .session_done    (session_done),
    .win_count       (win_count),
    .loss_count      (loss_count),
    .stim_win        (stim_win),
    .stim_loss       (stim_loss)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int start_hs_cnt = 0;
  int end_hs_cnt = 0;
  int done_cnt = 0;

  always @(posedge clk) begin
    if (game_start_valid && game_start_ready) start_hs_cnt <= start_hs_cnt + 1;
    if (game_end_valid && game_end_ready) end_hs_cnt <= end_hs_cnt + 1;
    if (session_done) done_cnt <= done_cnt + 1;
  end

  typedef struct {
    int         n_up;
    int         n_dn;
    int         n_both;
    logic [1:0] exp;
  } vec_t;

  vec_t vec[8];

  // Reference model of the paddle decision: per-window totals, clamped at the counter limit.
  int         m_up, m_dn, m_pos;
  logic [1:0] m_pad;
  int         exp_win, exp_loss;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] decide(input int u, input int d);
    int uc, dc;
    uc = (u > SAT) ? SAT : u;
    dc = (d > SAT) ? SAT : d;
    if (uc - dc >= MARGIN) return 2'b10;
    if (dc - uc >= MARGIN) return 2'b01;
    return 2'b00;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_up  = 0;
    m_dn  = 0;
    m_pos = 0;
    m_pad = 2'b00;
  endtask

  task automatic play_cycle(input logic su, input logic sd);
    check("paddle", {30'd0, paddle_control}, {30'd0, m_pad});
    spike_up   = su;
    spike_down = sd;
    m_up += int'(su);
    m_dn += int'(sd);
    if (m_pos == WINDOW - 1) begin
      m_pad = decide(m_up, m_dn);
      m_up  = 0;
      m_dn  = 0;
      m_pos = 0;
    end else begin
      m_pos++;
    end
    tick();
    spike_up   = 1'b0;
    spike_down = 1'b0;
  endtask

  task automatic begin_session();
    session_start = 1'b1;
    tick();
    session_start = 1'b0;
    check("start_valid_entry", {31'd0, game_start_valid}, 32'd1);
    check("busy_start", {31'd0, session_busy}, 32'd1);
    exp_win  = 0;
    exp_loss = 0;
  endtask

  task automatic start_handshake(input int delay);
    for (int i = 0; i < delay; i++) begin
      check("start_valid_hold", {31'd0, game_start_valid}, 32'd1);
      tick();
    end
    check("start_valid_hs", {31'd0, game_start_valid}, 32'd1);
    game_start_ready = 1'b1;
    tick();
    game_start_ready = 1'b0;
    check("start_valid_drop", {31'd0, game_start_valid}, 32'd0);
    model_reset();
  endtask

  task automatic deliver_result(input logic win);
    result_en   = 1'b1;
    game_result = win;
    tick();
    if (win) exp_win++;
    else exp_loss++;
    check("win_count", {24'd0, win_count}, exp_win);
    check("loss_count", {24'd0, loss_count}, exp_loss);
    check("stim_off", {30'd0, stim_win, stim_loss}, 32'd0);
  endtask

  task automatic wait_next(input bit want_end, input int exp_lat);
    int n;
    n = 0;
    while (!(want_end ? game_end_valid : game_start_valid) && n < 50) begin
      check("gap_busy", {31'd0, session_busy}, 32'd1);
      check("gap_paddle", {30'd0, paddle_control}, 32'd0);
      tick();
      n++;
    end
    if (want_end) check("end_latency", n, exp_lat);
    else check("start_latency", n, exp_lat);
  endtask

  task automatic end_handshake(input int delay);
    for (int i = 0; i < delay; i++) begin
      check("end_valid_hold", {31'd0, game_end_valid}, 32'd1);
      tick();
    end
    check("end_valid_hs", {31'd0, game_end_valid}, 32'd1);
    game_end_ready = 1'b1;
    tick();
    game_end_ready = 1'b0;
    check("end_valid_drop", {31'd0, game_end_valid}, 32'd0);
    check("done_pulse", {31'd0, session_done}, 32'd1);
    check("busy_idle", {31'd0, session_busy}, 32'd0);
    tick();
    check("done_once", {31'd0, session_done}, 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {game_start_valid, game_end_valid, paddle_control, session_busy, session_done,
                 win_count, loss_count, stim_win, stim_loss}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int s0, e0, d0, pu, pd, plen;
    bit stale, win;

    vec[0] = '{n_up: 5,   n_dn: 2, n_both: 0,   exp: 2'b10};
    vec[1] = '{n_up: 3,   n_dn: 2, n_both: 0,   exp: 2'b00};
    vec[2] = '{n_up: 2,   n_dn: 5, n_both: 0,   exp: 2'b01};
    vec[3] = '{n_up: 0,   n_dn: 2, n_both: 0,   exp: 2'b01};
    vec[4] = '{n_up: 0,   n_dn: 0, n_both: 300, exp: 2'b00};
    vec[5] = '{n_up: 2,   n_dn: 0, n_both: 298, exp: 2'b00};
    vec[6] = '{n_up: 258, n_dn: 3, n_both: 0,   exp: 2'b10};
    vec[7] = '{n_up: 1,   n_dn: 0, n_both: 0,   exp: 2'b00};

    #12;
    check_all_zero("reset_outputs");
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check_all_zero("idle_outputs");

    // Directed two-round session: start held off, decode vectors, stale result level.
    s0 = start_hs_cnt; e0 = end_hs_cnt; d0 = done_cnt;
    begin_session();
    check("counts_cleared", {win_count, loss_count}, 32'd0);
    start_handshake(10);
    for (int v = 0; v < 8; v++) begin
      for (int c = 0; c < WINDOW; c++) begin
        if (c < vec[v].n_up) play_cycle(1'b1, 1'b0);
        else if (c < vec[v].n_up + vec[v].n_dn) play_cycle(1'b0, 1'b1);
        else if (c < vec[v].n_up + vec[v].n_dn + vec[v].n_both) play_cycle(1'b1, 1'b1);
        else play_cycle(1'b0, 1'b0);
      end
      check("vec_paddle", {30'd0, paddle_control}, {30'd0, vec[v].exp});
    end
    deliver_result(1'b1);
    check("result_paddle", {30'd0, paddle_control}, 32'd0);
    wait_next(1'b0, 1 + GAP);
    start_handshake(0);
    for (int c = 0; c < 5; c++) play_cycle(1'b0, 1'b0);
    check("stale_win", {24'd0, win_count}, 32'd1);
    check("stale_loss", {24'd0, loss_count}, 32'd0);
    check("stale_still_play", {31'd0, game_start_valid | game_end_valid}, 32'd0);
    result_en = 1'b0;
    play_cycle(1'b0, 1'b0);
    deliver_result(1'b0);
    wait_next(1'b1, 1 + GAP);
    end_handshake(4);
    result_en = 1'b0;
    check("session_start_hs", start_hs_cnt - s0, NUM_ROUNDS);
    check("session_end_hs", end_hs_cnt - e0, 1);
    check("session_done_cnt", done_cnt - d0, 1);
    check("counts_preserved", {win_count, loss_count}, {16'd0, 8'd1, 8'd1});

    // Abort during PLAY of round 1.
    s0 = start_hs_cnt; e0 = end_hs_cnt; d0 = done_cnt;
    begin_session();
    check("counts_cleared2", {win_count, loss_count}, 32'd0);
    start_handshake(2);
    for (int c = 0; c < 7; c++) play_cycle(1'b1, 1'b0);
    session_abort = 1'b1;
    tick();
    session_abort = 1'b0;
    check("abort_end_valid", {31'd0, game_end_valid}, 32'd1);
    check("abort_counts", {win_count, loss_count}, 32'd0);
    end_handshake(5);
    check("abort_start_hs", start_hs_cnt - s0, 1);
    check("abort_end_hs", end_hs_cnt - e0, 1);
    check("abort_done_cnt", done_cnt - d0, 1);

    // Abort while the start request is still pending.
    begin_session();
    tick();
    session_abort = 1'b1;
    tick();
    session_abort = 1'b0;
    check("abort_start_hold", {31'd0, game_start_valid}, 32'd1);
    game_start_ready = 1'b1;
    tick();
    game_start_ready = 1'b0;
    check("abort_start_to_end", {30'd0, game_start_valid, game_end_valid}, 32'd1);
    end_handshake(0);

    // Abort alone in IDLE is ignored; start with abort in the same cycle starts.
    session_abort = 1'b1;
    tick();
    session_abort = 1'b0;
    check("idle_abort_ignored", {30'd0, session_busy, game_end_valid}, 32'd0);
    session_start = 1'b1;
    session_abort = 1'b1;
    tick();
    session_start = 1'b0;
    session_abort = 1'b0;
    check("start_wins", {30'd0, game_start_valid, game_end_valid}, 32'd2);
    start_handshake(0);
    check("start_wins_play", {31'd0, game_end_valid}, 32'd0);

    // Asynchronous reset in the middle of PLAY with the paddle driven up.
    for (int c = 0; c < WINDOW; c++) play_cycle(c < 5, 1'b0);
    for (int c = 0; c < 3; c++) play_cycle(1'b0, 1'b0);
    check("pre_reset_paddle", {30'd0, paddle_control}, 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset_outputs");
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check_all_zero("post_reset_idle");

    // Randomized sessions against the model.
    for (int s = 0; s < 3; s++) begin
      s0 = start_hs_cnt; e0 = end_hs_cnt; d0 = done_cnt;
      begin_session();
      pu = 0;
      pd = 0;
      for (int r = 0; r < NUM_ROUNDS; r++) begin
        start_handshake($urandom_range(0, 4));
        stale       = 1'($urandom_range(0, 1));
        result_en   = stale;
        game_result = 1'b1;
        plen        = $urandom_range(3, 700);
        for (int c = 0; c < plen; c++) begin
          if (m_pos == 0) begin
            pu = ($urandom_range(0, 3) == 0) ? $urandom_range(80, 100) : $urandom_range(0, 6);
            pd = ($urandom_range(0, 3) == 0) ? $urandom_range(80, 100) : $urandom_range(0, 6);
          end
          if (c == 1) result_en = 1'b0;
          play_cycle($urandom_range(0, 99) < pu, $urandom_range(0, 99) < pd);
        end
        win = 1'($urandom_range(0, 1));
        deliver_result(win);
        wait_next(r == NUM_ROUNDS - 1, 1 + GAP);
      end
      end_handshake($urandom_range(0, 4));
      check("rand_counts", {win_count, loss_count}, {16'd0, 8'(exp_win), 8'(exp_loss)});
      check("rand_start_hs", start_hs_cnt - s0, NUM_ROUNDS);
      check("rand_end_hs", end_hs_cnt - e0, 1);
      check("rand_done_cnt", done_cnt - d0, 1);
      result_en = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
